// File: rtl/tiny_calc_pkg.sv
// Shared constants and types for the tiny calculator sequencer.
package tiny_calc_pkg;
  localparam int WIDTH  = 4;
  localparam int STEP_W = 2;

  typedef enum logic [1:0] {IDLE, ADD, MUL, DONE} state_t;
  typedef enum logic {OP_ADD = 1'b0, OP_MUL = 1'b1} op_t;
endpackage

// File: rtl/tiny_alu_sequencer_if.sv
// Request/response bundle between the key/switch inputs and the sequencer.
interface tiny_alu_sequencer_if;
  import tiny_calc_pkg::*;

  logic                 start;
  logic                 op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/ripple_carry_adder_4.sv
// 4-bit ripple-carry adder, the single shared datapath of the sequencer.
module ripple_carry_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

// File: rtl/tiny_alu_sequencer.sv
// Time-shares one 4-bit adder to run add (1 pass) or shift-and-add multiply (4 passes).
module tiny_alu_sequencer
  import tiny_calc_pkg::*;
(
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  tiny_alu_sequencer_if.slave   bus
);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] p;
  logic [STEP_W-1:0]  step;

  logic [WIDTH-1:0]   add_x, add_y, add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] p_nxt;

  ripple_carry_adder_4 u_adder (
    .a    (add_x),
    .b    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Add uses A + B (B lives in P's low nibble); multiply adds A into P's high nibble when P[0] set.
  always_comb begin
    add_x = '0;
    add_y = '0;
    p_nxt = p;
    case (state)
      ADD: begin
        add_x = a_reg;
        add_y = p[WIDTH-1:0];
        p_nxt = {3'b000, add_cout, add_sum};
      end
      MUL: begin
        add_x = p[2*WIDTH-1:WIDTH];
        add_y = p[0] ? a_reg : '0;
        p_nxt = {add_cout, add_sum, p[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state      <= IDLE;
      a_reg      <= '0;
      p          <= '0;
      step       <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_reg    <= bus.a;
            p        <= {{WIDTH{1'b0}}, bus.b};
            step     <= '0;
            bus.busy <= 1'b1;
            state    <= (op_t'(bus.op) == OP_MUL) ? MUL : ADD;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        ADD: begin
          p          <= p_nxt;
          bus.result <= p_nxt;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= DONE;
        end
        MUL: begin
          p    <= p_nxt;
          step <= step + 1'b1;
          if (step == LAST_STEP) begin
            bus.result <= p_nxt;
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tiny_alu_sequencer.sv
// Randomized self-checking bench for tiny_alu_sequencer against an arithmetic reference.
module tb_tiny_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_result = 8'h00;

  tiny_alu_sequencer_if bus ();

  tiny_alu_sequencer dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_result(input logic o, input logic [3:0] x, input logic [3:0] y);
    return o ? 8'(x) * 8'(y) : 8'(x) + 8'(y);
  endfunction

  function automatic int ref_latency(input logic o);
    return o ? 5 : 2;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = 4'h0; bus.b = 4'h0;
    cyc(); cyc();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'h00) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h expected 0 0 00", bus.busy, bus.done, bus.result);
    end
    rst_n = 1'b1;
    last_result = 8'h00;
    cyc();
  endtask

  // One full operation, checking every cycle from 1 to latency+1.
  task automatic test_single_op(input string name, input logic o, input logic [3:0] x, input logic [3:0] y);
    logic [7:0] exp;
    int lat;
    exp = ref_result(o, x, y);
    lat = ref_latency(o);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k < lat; k++) begin
      bus.op = 1'($urandom); bus.a = 4'($urandom); bus.b = 4'($urandom);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result !== last_result) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b done=%b result=%h expected 1 0 %h",
                 name, k, bus.busy, bus.done, bus.result, last_result);
      end
      cyc();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== exp) begin
      errors++;
      $display("FAIL %s done cycle: busy=%b done=%b result=%h expected 0 1 %h",
               name, bus.busy, bus.done, bus.result, exp);
    end
    last_result = exp;
    cyc();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp) begin
      errors++;
      $display("FAIL %s after done: busy=%b done=%b result=%h expected 0 0 %h",
               name, bus.busy, bus.done, bus.result, exp);
    end
  endtask

  task automatic test_ignore_busy();
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 4'd3; bus.b = 4'd4;
    cyc();
    bus.start = 1'b0;
    cyc();
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd1; bus.b = 4'd1;
    cyc();
    bus.start = 1'b0;
    cyc(); cyc();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 8'h0C) begin
      errors++;
      $display("FAIL ignore_busy: done=%b result=%h expected 1 0c", bus.done, bus.result);
    end
    last_result = 8'h0C;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 8'h0C) begin
        errors++;
        $display("FAIL ignore_busy extra: done=%b busy=%b result=%h expected 0 0 0c", bus.done, bus.busy, bus.result);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_r;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'hF; bus.b = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 6) bus.start = 1'b0;
      exp_r = (k >= 2) ? 8'h1E : last_result;
      checks++;
      if (bus.done !== (k % 2 == 0) || bus.busy !== (k % 2 == 1) || bus.result !== exp_r) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: done=%b busy=%b result=%h expected %b %b %h",
                 k, bus.done, bus.busy, bus.result, (k % 2 == 0), (k % 2 == 1), exp_r);
      end
    end
    last_result = 8'h1E;
    cyc();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back release: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 4'd7; bus.b = 4'd9;
    cyc();
    bus.start = 1'b0;
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'h00) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b result=%h expected 0 0 00", bus.busy, bus.done, bus.result);
    end
    rst_n = 1'b1;
    last_result = 8'h00;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort stray: done=%b busy=%b expected 0 0", bus.done, bus.busy);
      end
    end
    test_single_op("add_2_3", 1'b0, 4'd2, 4'd3);
  endtask

  task automatic test_hold();
    test_single_op("add_4_4", 1'b0, 4'd4, 4'd4);
    for (int k = 0; k < 8; k++) begin
      bus.a = 4'($urandom); bus.b = 4'($urandom); bus.op = 1'($urandom);
      cyc();
      checks++;
      if (bus.done !== 1'b0 || bus.result !== 8'h08) begin
        errors++;
        $display("FAIL hold: done=%b result=%h expected 0 08", bus.done, bus.result);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      test_single_op("random", 1'($urandom), 4'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  initial begin
    test_reset();
    test_single_op("add_9_7",   1'b0, 4'd9,  4'd7);
    test_single_op("mul_15_15", 1'b1, 4'd15, 4'd15);
    test_single_op("mul_6_5",   1'b1, 4'd6,  4'd5);
    test_single_op("mul_13_0",  1'b1, 4'd13, 4'd0);
    test_single_op("add_15_15", 1'b0, 4'd15, 4'd15);
    test_single_op("mul_0_15",  1'b1, 4'd0,  4'd15);
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
